// File: rtl/ecr_alloc_controller.sv
// ECR allocator: round-robin grant of free ECRs,
// resolution snooping and dependent ref-counting.
module ecr_alloc_controller #(
  parameter int NUM_ECRS  = 2,
  parameter int NUM_SICS  = 2,
  parameter int REF_WIDTH = 4,
  localparam int IDW = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    alloc_req,
  output logic                    alloc_gnt,
  output logic [IDW-1:0]          alloc_id,
  input  logic                    dep_inc,
  input  logic [IDW-1:0]          dep_inc_id,
  output logic                    dep_ready,
  input  logic [NUM_SICS-1:0]     dep_dec,
  input  logic [NUM_SICS*IDW-1:0] dep_dec_id,
  input  logic [NUM_SICS-1:0]     sic_wen,
  input  logic [NUM_SICS*IDW-1:0] sic_write_addr,
  output logic                    issue_wen,
  output logic [IDW-1:0]          issue_write_addr,
  output logic [1:0]              issue_wdata,
  output logic [IDW:0]            free_count,
  output logic [NUM_ECRS-1:0]     ecr_busy,
  output logic                    err
);

  typedef enum logic [1:0] {
    S_FREE,
    S_PEND,
    S_RES
  } ecr_st_e;

  ecr_st_e              st_q  [NUM_ECRS];
  ecr_st_e              st_d  [NUM_ECRS];
  logic [REF_WIDTH-1:0] cnt_q [NUM_ECRS];
  logic [REF_WIDTH-1:0] cnt_d [NUM_ECRS];
  logic [IDW-1:0]       rr_q, rr_d;
  logic                 err_q, err_d;
  logic                 any_free;

  function automatic logic in_rng(input logic [IDW-1:0] id);
    return int'(id) < NUM_ECRS;
  endfunction

  // Round-robin search for the first FREE ECR from rr_q
  always_comb begin
    any_free = 1'b0;
    alloc_id = '0;
    for (int j = 0; j < NUM_ECRS; j++) begin
      automatic int idx = (int'(rr_q) + j) % NUM_ECRS;
      if (!any_free && st_q[idx] == S_FREE) begin
        any_free = 1'b1;
        alloc_id = IDW'(idx);
      end
    end
    alloc_gnt = alloc_req & any_free & ~flush & ~rst;
    if (!alloc_gnt) alloc_id = '0;
  end

  // Issue write port and status outputs
  always_comb begin
    issue_wen        = alloc_gnt;
    issue_write_addr = alloc_id;
    issue_wdata      = 2'b00;
    err              = err_q;
    free_count       = '0;
    ecr_busy         = '0;
    for (int k = 0; k < NUM_ECRS; k++) begin
      ecr_busy[k] = (st_q[k] != S_FREE);
      if (st_q[k] == S_FREE) free_count = free_count + 1'b1;
    end
    dep_ready = 1'b1;
    if (in_rng(dep_inc_id))
      dep_ready = (cnt_q[dep_inc_id] != '1);
  end

  // Next-state: counts, per-ECR lifetime FSMs, pointer, error
  always_comb begin
    err_d = err_q;
    rr_d  = rr_q;
    for (int k = 0; k < NUM_ECRS; k++) begin
      st_d[k]  = st_q[k];
      cnt_d[k] = cnt_q[k];
    end
    if (flush) begin
      rr_d = '0;
      for (int k = 0; k < NUM_ECRS; k++) begin
        st_d[k]  = S_FREE;
        cnt_d[k] = '0;
      end
    end else begin
      if (alloc_gnt)
        rr_d = IDW'((int'(alloc_id) + 1) % NUM_ECRS);
      if (dep_inc && !in_rng(dep_inc_id)) err_d = 1'b1;
      for (int i = 0; i < NUM_SICS; i++) begin
        if (dep_dec[i] && !in_rng(dep_dec_id[i*IDW +: IDW]))
          err_d = 1'b1;
        if (sic_wen[i] && !in_rng(sic_write_addr[i*IDW +: IDW]))
          err_d = 1'b1;
      end
      for (int k = 0; k < NUM_ECRS; k++) begin
        automatic logic [REF_WIDTH-1:0] c = cnt_q[k];
        automatic logic hit = 1'b0;
        if (dep_inc && dep_ready && int'(dep_inc_id) == k) begin
          if (st_q[k] == S_FREE) err_d = 1'b1;
          else c = c + 1'b1;
        end
        for (int i = 0; i < NUM_SICS; i++) begin
          if (dep_dec[i] && int'(dep_dec_id[i*IDW +: IDW]) == k) begin
            if (c == '0) err_d = 1'b1;
            else c = c - 1'b1;
          end
          if (sic_wen[i] && int'(sic_write_addr[i*IDW +: IDW]) == k)
            hit = 1'b1;
        end
        cnt_d[k] = c;
        case (st_q[k])
          S_FREE: begin
            if (hit) err_d = 1'b1;
            if (alloc_gnt && int'(alloc_id) == k) st_d[k] = S_PEND;
          end
          S_PEND: begin
            if (hit) st_d[k] = (c == '0) ? S_FREE : S_RES;
          end
          S_RES: begin
            if (hit) err_d = 1'b1;
            if (c == '0) st_d[k] = S_FREE;
          end
          default: st_d[k] = S_FREE;
        endcase
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= '0;
      err_q <= 1'b0;
      for (int k = 0; k < NUM_ECRS; k++) begin
        st_q[k]  <= S_FREE;
        cnt_q[k] <= '0;
      end
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
      for (int k = 0; k < NUM_ECRS; k++) begin
        st_q[k]  <= st_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_ecr_alloc_controller.sv
// Scoreboard bench for ecr_alloc_controller
// (NUM_ECRS=2, NUM_SICS=2, REF_WIDTH=2).
module tb_ecr_alloc_controller;

  logic       clk = 1'b0;
  logic       rst, flush, alloc_req;
  logic       alloc_gnt;
  logic [0:0] alloc_id;
  logic       dep_inc;
  logic [0:0] dep_inc_id;
  logic       dep_ready;
  logic [1:0] dep_dec;
  logic [1:0] dep_dec_id;
  logic [1:0] sic_wen;
  logic [1:0] sic_write_addr;
  logic       issue_wen;
  logic [0:0] issue_write_addr;
  logic [1:0] issue_wdata;
  logic [1:0] free_count;
  logic [1:0] ecr_busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       gnt;
    logic [0:0] id;
    logic [1:0] fc;
    logic [1:0] busy;
    logic       err;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  ecr_alloc_controller #(
    .NUM_ECRS(2), .NUM_SICS(2), .REF_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_id(alloc_id), .dep_inc(dep_inc),
    .dep_inc_id(dep_inc_id), .dep_ready(dep_ready),
    .dep_dec(dep_dec), .dep_dec_id(dep_dec_id),
    .sic_wen(sic_wen), .sic_write_addr(sic_write_addr),
    .issue_wen(issue_wen),
    .issue_write_addr(issue_write_addr),
    .issue_wdata(issue_wdata), .free_count(free_count),
    .ecr_busy(ecr_busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation each cycle one is queued
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      automatic exp_t e = sb.pop_front();
      cmp({e.name, ".gnt"}, int'(alloc_gnt), int'(e.gnt));
      cmp({e.name, ".wen"}, int'(issue_wen), int'(e.gnt));
      cmp({e.name, ".id"}, int'(alloc_id), int'(e.id));
      cmp({e.name, ".waddr"}, int'(issue_write_addr),
          int'(e.id));
      cmp({e.name, ".wdata"}, int'(issue_wdata), 0);
      cmp({e.name, ".free"}, int'(free_count), int'(e.fc));
      cmp({e.name, ".busy"}, int'(ecr_busy), int'(e.busy));
      cmp({e.name, ".err"}, int'(err), int'(e.err));
      cmp({e.name, ".rdy"}, int'(dep_ready), int'(e.rdy));
    end
  end

  task automatic clr();
    rst = 0; flush = 0; alloc_req = 0;
    dep_inc = 0; dep_inc_id = 0;
    dep_dec = 0; dep_dec_id = 0;
    sic_wen = 0; sic_write_addr = 0;
  endtask

  // Queue expectation for current inputs, then advance a cycle
  task automatic chk(input string nm, input logic g,
                     input logic [0:0] id, input logic [1:0] fc,
                     input logic [1:0] b, input logic e,
                     input logic r);
    exp_t x;
    x.name = nm; x.gnt = g; x.id = id; x.fc = fc;
    x.busy = b; x.err = e; x.rdy = r;
    sb.push_back(x);
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 1; alloc_req = 1;
    chk("reset", 0, 0, 2, 2'b00, 0, 1);

    alloc_req = 1; chk("alloc0", 1, 0, 2, 2'b00, 0, 1);
    alloc_req = 1; chk("alloc1", 1, 1, 1, 2'b01, 0, 1);
    alloc_req = 1; chk("alloc_full", 0, 0, 0, 2'b11, 0, 1);

    flush = 1; alloc_req = 1;
    chk("flush_cyc", 0, 0, 0, 2'b11, 0, 1);
    alloc_req = 1; chk("post_flush", 1, 0, 2, 2'b00, 0, 1);

    sic_wen = 2'b10; sic_write_addr = 2'b00;
    chk("resolve0", 0, 0, 1, 2'b01, 0, 1);
    chk("freed0", 0, 0, 2, 2'b00, 0, 1);

    alloc_req = 1; chk("rr_alloc1", 1, 1, 2, 2'b00, 0, 1);
    alloc_req = 1; chk("rr_alloc0", 1, 0, 1, 2'b10, 0, 1);
    dep_inc = 1; chk("inc0_a", 0, 0, 0, 2'b11, 0, 1);
    dep_inc = 1; chk("inc0_b", 0, 0, 0, 2'b11, 0, 1);
    sic_wen = 2'b01; sic_write_addr = 2'b00;
    chk("resolve_dep", 0, 0, 0, 2'b11, 0, 1);
    chk("held_res", 0, 0, 0, 2'b11, 0, 1);
    dep_dec = 2'b11; dep_dec_id = 2'b00;
    chk("dual_dec", 0, 0, 0, 2'b11, 0, 1);
    chk("res_freed", 0, 0, 1, 2'b10, 0, 1);

    dep_inc = 1; dep_inc_id = 1;
    chk("inc1_a", 0, 0, 1, 2'b10, 0, 1);
    dep_inc = 1; dep_inc_id = 1;
    chk("inc1_b", 0, 0, 1, 2'b10, 0, 1);
    dep_inc = 1; dep_inc_id = 1;
    chk("inc1_c", 0, 0, 1, 2'b10, 0, 1);
    dep_inc = 1; dep_inc_id = 1;
    chk("inc1_full", 0, 0, 1, 2'b10, 0, 0);
    dep_dec = 2'b01; dep_dec_id = 2'b01; dep_inc_id = 1;
    chk("dec1_a", 0, 0, 1, 2'b10, 0, 0);
    dep_inc_id = 1;
    chk("ready_back", 0, 0, 1, 2'b10, 0, 1);
    sic_wen = 2'b10; sic_write_addr = 2'b10;
    chk("resolve1", 0, 0, 1, 2'b10, 0, 1);
    chk("held1", 0, 0, 1, 2'b10, 0, 1);
    dep_dec = 2'b11; dep_dec_id = 2'b11;
    chk("dual_dec1", 0, 0, 1, 2'b10, 0, 1);
    chk("all_free", 0, 0, 2, 2'b00, 0, 1);

    dep_dec = 2'b01; dep_dec_id = 2'b00;
    chk("dec_free", 0, 0, 2, 2'b00, 0, 1);
    chk("err_set", 0, 0, 2, 2'b00, 1, 1);
    chk("err_held", 0, 0, 2, 2'b00, 1, 1);
    rst = 1; alloc_req = 1;
    chk("rst_cyc", 0, 0, 2, 2'b00, 1, 1);
    chk("err_clr", 0, 0, 2, 2'b00, 0, 1);

    sic_wen = 2'b01; sic_write_addr = 2'b01;
    chk("snoop_free", 0, 0, 2, 2'b00, 0, 1);
    flush = 1;
    chk("flush_err", 0, 0, 2, 2'b00, 1, 1);
    chk("err_kept", 0, 0, 2, 2'b00, 1, 1);
    rst = 1;
    chk("rst2", 0, 0, 2, 2'b00, 1, 1);

    dep_inc = 1; dep_inc_id = 1;
    chk("inc_free", 0, 0, 2, 2'b00, 0, 1);
    chk("inc_free_err", 0, 0, 2, 2'b00, 1, 1);
    rst = 1;
    chk("rst3", 0, 0, 2, 2'b00, 1, 1);

    alloc_req = 1; chk("b_alloc0", 1, 0, 2, 2'b00, 0, 1);
    alloc_req = 1; chk("b_alloc1", 1, 1, 1, 2'b01, 0, 1);
    alloc_req = 1; sic_wen = 2'b01; sic_write_addr = 2'b00;
    chk("no_same_cyc", 0, 0, 0, 2'b11, 0, 1);
    alloc_req = 1; chk("next_cyc", 1, 0, 1, 2'b10, 0, 1);

    for (int n = 0; n < 10 && sb.size() > 0; n++)
      @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
